// File: rtl/mcu_sys_pkg.sv
// mcu_sys_pkg: opcodes, FSM states and ID magic bytes for the MCU system-control target
package mcu_sys_pkg;
  localparam logic [7:0] OP_NOP        = 8'h00;
  localparam logic [7:0] OP_GET_ID     = 8'h01;
  localparam logic [7:0] OP_SET_CFG    = 8'h02;
  localparam logic [7:0] OP_GET_CFG    = 8'h03;
  localparam logic [7:0] OP_GET_STATUS = 8'h04;
  localparam logic [7:0] OP_CORE_RST   = 8'h05;
  localparam logic [7:0] ID_MAGIC0     = 8'h5C;
  localparam logic [7:0] ID_MAGIC1     = 8'h42;
  typedef enum logic [3:0] {
    IDLE, ID, CFG_ADDR, CFG_WR, RD_ADDR, CFG_RD, STATUS, RST, DISCARD
  } state_t;
endpackage

// File: rtl/mcu_sys_cfg_regs.sv
// mcu_sys_cfg_regs: 8-bit config register file with one write port and an indexed read mux
module mcu_sys_cfg_regs #(
  parameter int NUM_CFG = 8
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       we,
  input  logic [$clog2(NUM_CFG)-1:0] widx,
  input  logic [7:0]                 wdata,
  input  logic [$clog2(NUM_CFG)-1:0] ridx,
  output logic [7:0]                 rdata,
  output logic [8*NUM_CFG-1:0]       cfg,
  output logic                       cfg_wr,
  output logic [3:0]                 cfg_wr_idx
);
  assign rdata = cfg[{ridx, 3'b000} +: 8];
  always_ff @(posedge clk) begin
    if (reset) begin
      cfg        <= '0;
      cfg_wr     <= 1'b0;
      cfg_wr_idx <= 4'd0;
    end else begin
      cfg_wr <= we;
      if (we) begin
        cfg[{widx, 3'b000} +: 8] <= wdata;
        cfg_wr_idx               <= 4'(widx);
      end
    end
  end
endmodule

// File: rtl/mcu_sys_target.sv
// mcu_sys_target: MCU target-0 command handler owning config registers, core reset and status interrupt
module mcu_sys_target
  import mcu_sys_pkg::*;
#(
  parameter logic [7:0] CORE_ID = 8'h01,
  parameter int         NUM_CFG = 8
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 mcu_active,
  input  logic                 mcu_sys_strobe,
  input  logic [7:0]           mcu_dout,
  output logic [7:0]           mcu_sys_din,
  output logic [8*NUM_CFG-1:0] cfg,
  output logic                 cfg_wr,
  output logic [3:0]           cfg_wr_idx,
  output logic                 core_reset,
  input  logic [15:0]          status_in,
  output logic                 mcu_int
);
  localparam int IW = $clog2(NUM_CFG);
  state_t        state;
  logic [IW-1:0] idx, rd_idx;
  logic [1:0]    cnt;
  logic [15:0]   snap;
  logic [7:0]    rdata;
  logic          strobe, we;
  assign strobe = mcu_active & mcu_sys_strobe;
  assign we     = strobe & (state == CFG_WR);
  // read address is the index that will be current after this strobe
  assign rd_idx = (state == RD_ADDR) ? mcu_dout[IW-1:0] : idx + 1'b1;
  mcu_sys_cfg_regs #(.NUM_CFG(NUM_CFG)) u_regs (
    .clk(clk), .reset(reset), .we(we), .widx(idx), .wdata(mcu_dout),
    .ridx(rd_idx), .rdata(rdata), .cfg(cfg), .cfg_wr(cfg_wr), .cfg_wr_idx(cfg_wr_idx)
  );
  always_ff @(posedge clk) begin
    if (reset) begin
      state       <= IDLE;
      mcu_sys_din <= 8'h00;
      idx         <= '0;
      cnt         <= 2'd0;
      snap        <= 16'h0000;
      mcu_int     <= 1'b0;
      core_reset  <= 1'b0;
    end else begin
      // a change coinciding with GET_STATUS is absorbed into snap, never lost
      if (strobe && state == IDLE && mcu_dout == OP_GET_STATUS) begin
        snap    <= status_in;
        mcu_int <= 1'b0;
      end else if (status_in != snap) mcu_int <= 1'b1;
      if (!mcu_active) begin
        state       <= IDLE;
        mcu_sys_din <= 8'h00;
      end else if (strobe) begin
        cnt         <= (cnt == 2'd3) ? cnt : cnt + 2'd1;
        mcu_sys_din <= 8'h00;
        case (state)
          IDLE: begin
            cnt <= 2'd0;
            case (mcu_dout)
              OP_GET_ID: begin
                state       <= ID;
                mcu_sys_din <= ID_MAGIC0;
              end
              OP_SET_CFG: state <= CFG_ADDR;
              OP_GET_CFG: state <= RD_ADDR;
              OP_GET_STATUS: begin
                state       <= STATUS;
                mcu_sys_din <= status_in[7:0];
              end
              OP_CORE_RST: state <= RST;
              default: state <= DISCARD;
            endcase
          end
          ID: mcu_sys_din <= (cnt == 2'd0) ? ID_MAGIC1 : (cnt == 2'd1) ? CORE_ID :
                             (cnt == 2'd2) ? 8'(NUM_CFG) : 8'h00;
          CFG_ADDR: begin
            idx   <= mcu_dout[IW-1:0];
            state <= CFG_WR;
          end
          CFG_WR: idx <= idx + 1'b1;
          RD_ADDR: begin
            idx         <= mcu_dout[IW-1:0];
            state       <= CFG_RD;
            mcu_sys_din <= rdata;
          end
          CFG_RD: begin
            idx         <= idx + 1'b1;
            mcu_sys_din <= rdata;
          end
          STATUS: mcu_sys_din <= (cnt == 2'd0) ? snap[15:8] : 8'h00;
          RST: begin
            core_reset <= mcu_dout[0];
            state      <= DISCARD;
          end
          default: ;
        endcase
      end
    end
  end
endmodule

// File: tb/tb_mcu_sys_target.sv
// tb_mcu_sys_target: directed self-checking bench for mcu_sys_target
module tb_mcu_sys_target;
  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        mcu_active = 1'b0;
  logic        mcu_sys_strobe = 1'b0;
  logic [7:0]  mcu_dout = 8'h00;
  logic [7:0]  mcu_sys_din;
  logic [63:0] cfg;
  logic        cfg_wr;
  logic [3:0]  cfg_wr_idx;
  logic        core_reset;
  logic [15:0] status_in = 16'h0000;
  logic        mcu_int;
  int vectors = 0;
  int errors = 0;
  int wr_cnt = 0;

  mcu_sys_target dut (
    .clk(clk), .reset(reset), .mcu_active(mcu_active), .mcu_sys_strobe(mcu_sys_strobe),
    .mcu_dout(mcu_dout), .mcu_sys_din(mcu_sys_din), .cfg(cfg), .cfg_wr(cfg_wr),
    .cfg_wr_idx(cfg_wr_idx), .core_reset(core_reset), .status_in(status_in), .mcu_int(mcu_int)
  );

  always #5 clk = ~clk;
  always @(posedge clk) if (cfg_wr) wr_cnt++;

  task automatic send(input logic [7:0] b);
    @(negedge clk);
    mcu_dout = b;
    mcu_sys_strobe = 1'b1;
    @(negedge clk);
    mcu_sys_strobe = 1'b0;
  endtask

  task automatic start_tx();
    @(negedge clk);
    mcu_active = 1'b1;
  endtask

  task automatic end_tx();
    @(negedge clk);
    mcu_active = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_reset();
    repeat (2) @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    vectors++; if (mcu_sys_din !== 8'h00) begin errors++; $display("FAIL reset_din: got %h want 00", mcu_sys_din); end
    vectors++; if (cfg !== 64'h0) begin errors++; $display("FAIL reset_cfg: got %h want 0", cfg); end
    vectors++; if (cfg_wr !== 1'b0 || cfg_wr_idx !== 4'd0) begin errors++; $display("FAIL reset_wr: got %b/%h want 0/0", cfg_wr, cfg_wr_idx); end
    vectors++; if (core_reset !== 1'b0 || mcu_int !== 1'b0) begin errors++; $display("FAIL reset_rst_int: got %b/%b want 0/0", core_reset, mcu_int); end
  endtask

  task automatic test_get_id();
    logic [7:0] exp [6] = '{8'h5C, 8'h42, 8'h01, 8'h08, 8'h00, 8'h00};
    start_tx();
    for (int i = 0; i < 6; i++) begin
      send(i == 0 ? 8'h01 : 8'hE0 + 8'(i));
      vectors++; if (mcu_sys_din !== exp[i]) begin errors++; $display("FAIL get_id[%0d]: got %h want %h", i, mcu_sys_din, exp[i]); end
    end
    end_tx();
    vectors++; if (mcu_sys_din !== 8'h00) begin errors++; $display("FAIL idle_din: got %h want 00", mcu_sys_din); end
  endtask

  task automatic test_set_cfg_wrap();
    logic [7:0] dat [3] = '{8'hAA, 8'hBB, 8'hCC};
    logic [3:0] ix [3] = '{4'd6, 4'd7, 4'd0};
    start_tx();
    send(8'h02);
    send(8'h06);
    for (int i = 0; i < 3; i++) begin
      send(dat[i]);
      vectors++; if (cfg_wr !== 1'b1 || cfg_wr_idx !== ix[i]) begin errors++; $display("FAIL set_cfg_wr[%0d]: got %b/%h want 1/%h", i, cfg_wr, cfg_wr_idx, ix[i]); end
      vectors++; if (cfg[8*ix[i] +: 8] !== dat[i]) begin errors++; $display("FAIL set_cfg_val[%0d]: got %h want %h", i, cfg[8*ix[i] +: 8], dat[i]); end
    end
    end_tx();
    vectors++; if (cfg_wr !== 1'b0) begin errors++; $display("FAIL cfg_wr_pulse: got %b want 0", cfg_wr); end
    vectors++; if (cfg !== 64'hBBAA_0000_0000_00CC) begin errors++; $display("FAIL cfg_all: got %h want bbaa0000000000cc", cfg); end
    start_tx();
    send(8'h03);
    send(8'h07);
    vectors++; if (mcu_sys_din !== 8'hBB) begin errors++; $display("FAIL get_cfg7: got %h want bb", mcu_sys_din); end
    send(8'h00);
    vectors++; if (mcu_sys_din !== 8'hCC) begin errors++; $display("FAIL get_cfg_wrap: got %h want cc", mcu_sys_din); end
    end_tx();
  endtask

  task automatic test_status();
    @(negedge clk);
    status_in = 16'h1234;
    @(negedge clk);
    vectors++; if (mcu_int !== 1'b1) begin errors++; $display("FAIL int_set: got %b want 1", mcu_int); end
    start_tx();
    send(8'h04);
    vectors++; if (mcu_sys_din !== 8'h34 || mcu_int !== 1'b0) begin errors++; $display("FAIL status_lo: got %h/%b want 34/0", mcu_sys_din, mcu_int); end
    send(8'h00);
    vectors++; if (mcu_sys_din !== 8'h12) begin errors++; $display("FAIL status_hi: got %h want 12", mcu_sys_din); end
    send(8'h00);
    vectors++; if (mcu_sys_din !== 8'h00) begin errors++; $display("FAIL status_tail: got %h want 00", mcu_sys_din); end
    end_tx();
    vectors++; if (mcu_int !== 1'b0) begin errors++; $display("FAIL int_stays_clear: got %b want 0", mcu_int); end
    start_tx();
    @(negedge clk);
    mcu_dout = 8'h04;
    mcu_sys_strobe = 1'b1;
    status_in = 16'h5678;
    @(negedge clk);
    mcu_sys_strobe = 1'b0;
    vectors++; if (mcu_sys_din !== 8'h78 || mcu_int !== 1'b0) begin errors++; $display("FAIL status_coincide: got %h/%b want 78/0", mcu_sys_din, mcu_int); end
    send(8'h00);
    vectors++; if (mcu_sys_din !== 8'h56 || mcu_int !== 1'b0) begin errors++; $display("FAIL status_coincide_hi: got %h/%b want 56/0", mcu_sys_din, mcu_int); end
    end_tx();
  endtask

  task automatic test_core_rst();
    start_tx();
    send(8'h05);
    send(8'h01);
    vectors++; if (core_reset !== 1'b1) begin errors++; $display("FAIL core_rst_set: got %b want 1", core_reset); end
    send(8'h00);
    vectors++; if (core_reset !== 1'b1) begin errors++; $display("FAIL core_rst_ignore: got %b want 1", core_reset); end
    end_tx();
    start_tx();
    send(8'h05);
    send(8'h00);
    vectors++; if (core_reset !== 1'b0) begin errors++; $display("FAIL core_rst_clr: got %b want 0", core_reset); end
    end_tx();
  endtask

  task automatic test_abort();
    start_tx();
    send(8'h02);
    send(8'h03);
    send(8'h55);
    end_tx();
    start_tx();
    send(8'h03);
    send(8'h03);
    vectors++; if (mcu_sys_din !== 8'h55) begin errors++; $display("FAIL abort_readback: got %h want 55", mcu_sys_din); end
    end_tx();
    start_tx();
    send(8'h02);
    send(8'h01);
    send(8'h11);
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    vectors++; if (cfg !== 64'h0 || core_reset !== 1'b0 || mcu_sys_din !== 8'h00) begin errors++; $display("FAIL mid_reset: got cfg %h rst %b din %h want 0/0/00", cfg, core_reset, mcu_sys_din); end
    send(8'h01);
    vectors++; if (mcu_sys_din !== 8'h5C) begin errors++; $display("FAIL post_reset_cmd: got %h want 5c", mcu_sys_din); end
    end_tx();
  endtask

  task automatic test_unknown();
    logic [7:0] cmd [2] = '{8'h7F, 8'h00};
    wr_cnt = 0;
    send(8'h02);
    for (int c = 0; c < 2; c++) begin
      start_tx();
      send(cmd[c]);
      for (int i = 0; i < 3; i++) begin
        send(8'h02 + 8'(i));
        vectors++; if (mcu_sys_din !== 8'h00) begin errors++; $display("FAIL discard_din[%0d/%0d]: got %h want 00", c, i, mcu_sys_din); end
      end
      end_tx();
    end
    vectors++; if (wr_cnt !== 0 || cfg !== 64'h0) begin errors++; $display("FAIL discard_nowrite: got %0d writes cfg %h want 0/0", wr_cnt, cfg); end
    start_tx();
    send(8'h01);
    vectors++; if (mcu_sys_din !== 8'h5C) begin errors++; $display("FAIL inactive_ignored: got %h want 5c", mcu_sys_din); end
    end_tx();
  endtask

  initial begin
    test_reset();
    test_get_id();
    test_set_cfg_wrap();
    test_status();
    test_core_rst();
    test_abort();
    test_unknown();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: bench did not complete");
    $fatal(1);
  end
endmodule
